sorted_merge: RTL

- Consumer stage directly downstream of insertion_sort.
- Two insertion_sort instances are drained by pops into this block's bank A and bank B.
- A merge command interleaves both ascending sequences into one ascending output buffer, one element per cycle (CLRS 2.3 MERGE).
- The result is read back with pops using the same edge-triggered command style as insertion_sort.

---
 rtl/sorted_merge_pkg.sv | 13 +
 rtl/sorted_merge_rise_detect.sv | 18 +
 rtl/sorted_merge.sv | 117 +++++++++++
 3 files changed

// File: rtl/sorted_merge_pkg.sv
// Shared types and sizing for the two-bank sorted merge stage.
// Default widths match the upstream insertion_sort build.
package sorted_merge_pkg;
  localparam int SM_W   = 16;
  localparam int SM_AW  = 8;
  localparam int DEPTH  = 2 ** SM_AW;
  localparam int ODEPTH = 2 ** (SM_AW + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;
endpackage

// File: rtl/sorted_merge_rise_detect.sv
// One-cycle pulse on a rising command level, qualified by enable.
// Zero latency from the level; the history register samples every cycle.
module rise_detect (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic d,
  output logic ev
);
  logic d_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign ev = d & ~d_q & en;
endmodule

// File: rtl/sorted_merge.sv
// Merges two ascending banks into one ascending buffer, one element per cycle.
// Edge-triggered commands; commands outside IDLE (except clear) are dropped, never queued.
module sorted_merge
  import sorted_merge_pkg::*;
#(
  parameter int W  = SM_W,
  parameter int AW = SM_AW
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enable,
  input  logic [W-1:0] din,
  input  logic         push_a,
  input  logic         push_b,
  input  logic         merge,
  input  logic         pop,
  input  logic         clear,
  output logic [W-1:0] dout,
  output logic         full_a,
  output logic         full_b,
  output logic         empty,
  output logic         idle
);
  state_t        state;
  logic [AW:0]   na, nb, i, j;
  logic [AW+1:0] nc, k, rd;

  logic [W-1:0] mem_a [2**AW];
  logic [W-1:0] mem_b [2**AW];
  logic [W-1:0] mem_c [2**(AW+1)];

  logic pa_ev, pb_ev, mrg_ev, pop_ev, clr_ev;

  rise_detect u_rd_pa  (.clk(clk), .rstn(rstn), .en(enable), .d(push_a), .ev(pa_ev));
  rise_detect u_rd_pb  (.clk(clk), .rstn(rstn), .en(enable), .d(push_b), .ev(pb_ev));
  rise_detect u_rd_mrg (.clk(clk), .rstn(rstn), .en(enable), .d(merge),  .ev(mrg_ev));
  rise_detect u_rd_pop (.clk(clk), .rstn(rstn), .en(enable), .d(pop),    .ev(pop_ev));
  rise_detect u_rd_clr (.clk(clk), .rstn(rstn), .en(enable), .d(clear),  .ev(clr_ev));

  // Counts never exceed 2**AW, so the top bit alone marks a full bank.
  assign full_a = na[AW];
  assign full_b = nb[AW];
  assign empty  = (rd == nc);
  assign idle   = (state == IDLE);

  logic [W-1:0] a_v, b_v;
  logic         take_a, idle_cmd, wr_a, wr_b, wr_c, rd_c;

  assign a_v    = mem_a[i[AW-1:0]];
  assign b_v    = mem_b[j[AW-1:0]];
  // Ties favour A so equal keys keep their bank order.
  assign take_a = (i != na) && ((j == nb) || (a_v <= b_v));

  assign idle_cmd = (state == IDLE) && !clr_ev && !mrg_ev;
  assign wr_a     = idle_cmd && pa_ev && !full_a;
  assign wr_b     = idle_cmd && pb_ev && !full_b;
  assign rd_c     = idle_cmd && pop_ev && !empty;
  assign wr_c     = (state == MERGE) && enable && !clr_ev && (k != nc);

  always_ff @(posedge clk) begin
    if (wr_a) mem_a[na[AW-1:0]] <= din;
    if (wr_b) mem_b[nb[AW-1:0]] <= din;
    if (wr_c) mem_c[k[AW:0]]    <= take_a ? a_v : b_v;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      na    <= '0;
      nb    <= '0;
      nc    <= '0;
      rd    <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      dout  <= '0;
    end else if (clr_ev) begin
      state <= IDLE;
      na    <= '0;
      nb    <= '0;
      nc    <= '0;
      rd    <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (mrg_ev) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            rd    <= '0;
            nc    <= {1'b0, na} + {1'b0, nb};
            state <= MERGE;
          end else begin
            if (wr_a) na <= na + 1'b1;
            if (wr_b) nb <= nb + 1'b1;
            if (rd_c) begin
              dout <= mem_c[rd[AW:0]];
              rd   <= rd + 1'b1;
            end
          end
        end
        MERGE: begin
          if (k == nc) begin
            state <= IDLE;
            na    <= '0;
            nb    <= '0;
          end else begin
            k <= k + 1'b1;
            if (take_a) i <= i + 1'b1;
            else        j <= j + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
